// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded instruction fields, builds a 32-bit word
// and writes it sequentially into a 64-word instruction memory.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op_class,
  input  logic [2:0]  alu_op,
  input  logic [3:0]  cond,
  input  logic        imm,
  input  logic        s_bit,
  input  logic        ld,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] br_off,
  input  logic        flush,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic [6:0]  count,
  output logic        err,
  output logic        full
);

  // state | meaning
  // IDLE  | waiting for a request, flush accepted
  // ENC   | fields registered, word being built
  // WRITE | one-cycle memory write of the built word
  // FULL  | address 63 written, only flush leaves
  typedef enum logic [1:0] {IDLE, ENC, WRITE, FULL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_class_q;
  logic [2:0]  alu_op_q;
  logic [3:0]  cond_q, rn_q, rd_q;
  logic        imm_q, s_bit_q, ld_q;
  logic [11:0] src2_q;
  logic [23:0] br_off_q;
  logic [31:0] word_q, word_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [6:0]  count_q, count_d;
  logic        err_q, err_d;

  logic        transfer;
  logic        illegal;
  logic [3:0]  cmd;
  logic [3:0]  rn_eff;
  logic [31:0] enc_word;

  assign in_ready = (state_q == IDLE) & ~flush;
  assign transfer = in_valid & in_ready;

  always_comb begin
    cmd = 4'b0000;
    case (alu_op_q)
      3'b000:  cmd = 4'b0100;
      3'b001:  cmd = 4'b0010;
      3'b010:  cmd = 4'b0000;
      3'b011:  cmd = 4'b1100;
      3'b101:  cmd = 4'b0001;
      3'b110:  cmd = 4'b1111;
      default: cmd = 4'b0000;
    endcase
  end

  // mvn has no first operand; its rn field is encoded as zero
  assign rn_eff  = (alu_op_q == 3'b110) ? 4'b0000 : rn_q;
  assign illegal = (op_class_q == 2'b11) |
                   ((op_class_q == 2'b00) & ((alu_op_q == 3'b100) | (alu_op_q == 3'b111)));

  always_comb begin
    enc_word = 32'h0;
    case (op_class_q)
      2'b00:   enc_word = {cond_q, 2'b00, imm_q, cmd, s_bit_q, rn_eff, rd_q, src2_q};
      2'b01:   enc_word = {cond_q, 2'b01, 5'b01100, ld_q, rn_q, rd_q, src2_q};
      2'b10:   enc_word = {cond_q, 2'b10, 2'b10, br_off_q};
      default: enc_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          ptr_d   = 6'd0;
          count_d = 7'd0;
          err_d   = 1'b0;
        end else if (in_valid) begin
          state_d = ENC;
        end
      end
      ENC: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          word_d  = enc_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = (count_q == 7'd64) ? count_q : count_q + 7'd1;
        if (ptr_q == 6'd63) begin
          state_d = FULL;
        end else begin
          ptr_d   = ptr_q + 6'd1;
          state_d = IDLE;
        end
      end
      FULL: begin
        if (flush) begin
          ptr_d   = 6'd0;
          count_d = 7'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= 32'h0;
      ptr_q   <= 6'd0;
      count_q <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_class_q <= 2'b00;
      alu_op_q   <= 3'b000;
      cond_q     <= 4'h0;
      imm_q      <= 1'b0;
      s_bit_q    <= 1'b0;
      ld_q       <= 1'b0;
      rn_q       <= 4'h0;
      rd_q       <= 4'h0;
      src2_q     <= 12'h0;
      br_off_q   <= 24'h0;
    end else if (transfer) begin
      op_class_q <= op_class;
      alu_op_q   <= alu_op;
      cond_q     <= cond;
      imm_q      <= imm;
      s_bit_q    <= s_bit;
      ld_q       <= ld;
      rn_q       <= rn;
      rd_q       <= rd;
      src2_q     <= src2;
      br_off_q   <= br_off;
    end
  end

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = ptr_q;
  assign imem_wdata = word_q;
  assign count      = count_q;
  assign err        = err_q;
  assign full       = (state_q == FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: transaction-level model compared every
// cycle, plus literal expectations for the documented example words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op_class = '0;
  logic [2:0]  alu_op = '0;
  logic [3:0]  cond = '0;
  logic        imm = 1'b0;
  logic        s_bit = 1'b0;
  logic        ld = 1'b0;
  logic [3:0]  rn = '0;
  logic [3:0]  rd = '0;
  logic [11:0] src2 = '0;
  logic [23:0] br_off = '0;
  logic        flush = 1'b0;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;
  logic        err;
  logic        full;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .alu_op(alu_op), .cond(cond), .imm(imm), .s_bit(s_bit),
    .ld(ld), .rn(rn), .rd(rd), .src2(src2), .br_off(br_off), .flush(flush),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .err(err), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int opc; int alu; int cnd; int im; int s; int l;
    int n; int d; int src; int off;
  } req_t;

  typedef struct { int due; logic [31:0] word; } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t         pq[$];
  int          m_count = 0;
  bit          m_err = 0;
  bit          m_full = 0;
  int          busy_until = 0;
  int          err_at = -1;
  bit          acc = 0;
  logic [31:0] last_wdata = '0;
  logic [5:0]  last_addr = '0;
  int          wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Word an instruction must encode to; bit 32 set when the request is legal.
  function automatic logic [32:0] model_encode(input int opc, input int alu, input int cnd,
      input int im, input int s, input int l, input int n, input int d, input int src,
      input int off);
    int          cmd_of[8];
    int unsigned w;
    cmd_of = '{4, 2, 0, 12, -1, 1, 15, -1};
    w = 0;
    if (opc == 3 || (opc == 0 && cmd_of[alu] < 0)) return {1'b0, 32'h0};
    w = 32'(cnd) * 32'h1000_0000;
    if (opc == 0) begin
      w = w + 32'(im) * 32'h0200_0000 + 32'(cmd_of[alu]) * 32'h0020_0000
            + 32'(s) * 32'h0010_0000 + ((alu == 6) ? 0 : 32'(n) * 32'h0001_0000)
            + 32'(d) * 32'h1000 + 32'(src);
    end else if (opc == 1) begin
      w = w + 32'h0580_0000 + 32'(l) * 32'h0010_0000 + 32'(n) * 32'h0001_0000
            + 32'(d) * 32'h1000 + 32'(src);
    end else begin
      w = w + 32'h0A00_0000 + 32'(off);
    end
    return {1'b1, w};
  endfunction

  always @(negedge clk) begin
    logic        exp_we;
    logic        ready;
    logic [32:0] e;
    if (reset) begin
      pq.delete();
      m_count = 0; m_err = 0; m_full = 0; busy_until = 0; err_at = -1; acc = 0;
      chk("rst_we", {31'b0, imem_we}, 0);
      chk("rst_wdata", imem_wdata, 0);
      chk("rst_addr", {26'b0, imem_addr}, 0);
      chk("rst_count", {25'b0, count}, 0);
      chk("rst_err", {31'b0, err}, 0);
      chk("rst_full", {31'b0, full}, 0);
      chk("rst_ready", {31'b0, in_ready}, 1);
    end else begin
      exp_we = (pq.size() > 0) && (pq[0].due == cyc);
      ready  = !flush && (cyc >= busy_until) && !m_full;
      chk("imem_we", {31'b0, imem_we}, {31'b0, exp_we});
      chk("in_ready", {31'b0, in_ready}, {31'b0, ready});
      chk("count", {25'b0, count}, 32'(m_count));
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("full", {31'b0, full}, {31'b0, m_full});
      chk("imem_addr", {26'b0, imem_addr}, (m_count > 63) ? 32'd63 : 32'(m_count));
      if (imem_we) begin
        last_wdata = imem_wdata;
        last_addr  = imem_addr;
        wr_cnt++;
      end
      if (exp_we) begin
        chk("imem_wdata", imem_wdata, pq[0].word);
        void'(pq.pop_front());
        if (m_count < 64) m_count++;
        if (m_count == 64) m_full = 1;
      end
      if (err_at == cyc) m_err = 1;
      if (flush && cyc >= busy_until) begin
        m_count = 0; m_err = 0; m_full = 0;
      end else if (in_valid && ready) begin
        acc = 1;
        e = model_encode(int'(op_class), int'(alu_op), int'(cond), int'(imm), int'(s_bit),
                         int'(ld), int'(rn), int'(rd), int'(src2), int'(br_off));
        if (e[32]) begin
          pq.push_back('{due: cyc + 2, word: e[31:0]});
          busy_until = cyc + 3;
        end else begin
          err_at     = cyc + 1;
          busy_until = cyc + 2;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_t r);
    op_class = 2'(r.opc); alu_op = 3'(r.alu); cond = 4'(r.cnd); imm = 1'(r.im);
    s_bit = 1'(r.s); ld = 1'(r.l); rn = 4'(r.n); rd = 4'(r.d);
    src2 = 12'(r.src); br_off = 24'(r.off);
  endtask

  // Returns one ns after the accepting edge (first ENC cycle).
  task automatic send(input req_t r);
    int n;
    drive(r);
    acc = 0;
    in_valid = 1'b1;
    n = 0;
    while (!acc && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout at cycle %0d: request not accepted within 30 cycles", cyc);
    end
    acc = 0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
  endtask

  function automatic req_t mk(input int opc, input int alu, input int cnd, input int im,
      input int s, input int l, input int n, input int d, input int src, input int off);
    req_t r;
    r = '{opc, alu, cnd, im, s, l, n, d, src, off};
    return r;
  endfunction

  initial begin
    int saved;
    int legal_alu[6];
    legal_alu = '{0, 1, 2, 3, 5, 6};

    chk("model_add_imm", model_encode(0, 0, 14, 1, 0, 0, 2, 1, 5, 0), {1'b1, 32'hE2821005});
    chk("model_ldr", model_encode(1, 0, 14, 0, 0, 1, 1, 0, 8, 0), {1'b1, 32'hE5910008});
    chk("model_illegal", {31'b0, model_encode(0, 4, 14, 0, 0, 0, 1, 1, 0, 0)}, 0);

    idle(3);
    reset = 1'b0;
    idle(2);

    send(mk(0, 0, 14, 1, 0, 0, 2, 1, 12'h005, 0));
    idle(2);
    chk("add_imm_word", last_wdata, 32'hE2821005);
    chk("add_imm_addr", {26'b0, last_addr}, 0);
    chk("add_imm_count", {25'b0, count}, 1);

    pulse_flush();
    send(mk(0, 1, 14, 0, 0, 0, 4, 3, 12'h005, 0));
    idle(2);
    chk("sub_reg_word", last_wdata, 32'hE0443005);
    chk("sub_reg_addr", {26'b0, last_addr}, 0);
    send(mk(1, 0, 14, 0, 0, 1, 1, 0, 12'h008, 0));
    idle(2);
    chk("ldr_word", last_wdata, 32'hE5910008);
    chk("ldr_addr", {26'b0, last_addr}, 1);

    pulse_flush();
    send(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 24'h000003));
    idle(2);
    chk("branch_word", last_wdata, 32'h0A000003);
    saved = wr_cnt;
    send(mk(3, 0, 14, 0, 0, 0, 1, 1, 0, 0));
    idle(2);
    chk("illegal_err", {31'b0, err}, 1);
    chk("illegal_nowrite", 32'(wr_cnt), 32'(saved));
    chk("illegal_count", {25'b0, count}, 1);
    send(mk(0, 6, 14, 1, 1, 0, 7, 2, 12'h0FF, 0));
    idle(2);
    chk("mvn_word", last_wdata, 32'hE3F020FF);
    chk("mvn_addr", {26'b0, last_addr}, 1);
    chk("err_sticky", {31'b0, err}, 1);
    saved = wr_cnt;
    send(mk(0, 7, 14, 0, 0, 0, 1, 1, 0, 0));
    idle(2);
    chk("illegal_alu_nowrite", 32'(wr_cnt), 32'(saved));

    send(mk(0, 5, 1, 0, 1, 0, 9, 8, 12'hA5A, 0));
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(1);
    chk("flush_in_enc_ignored", last_wdata, 32'h1039_8A5A);
    chk("flush_in_enc_count", {25'b0, count}, 3);

    saved = wr_cnt;
    drive(mk(0, 0, 14, 1, 0, 0, 2, 1, 5, 0));
    in_valid = 1'b1;
    flush = 1'b1;
    idle(1);
    in_valid = 1'b0;
    flush = 1'b0;
    idle(3);
    chk("flush_wins_nowrite", 32'(wr_cnt), 32'(saved));
    chk("flush_wins_count", {25'b0, count}, 0);
    chk("flush_clears_err", {31'b0, err}, 0);

    for (int i = 0; i < 64; i++)
      send(mk(i % 3, legal_alu[i % 6], i % 15, i % 2, (i / 2) % 2, i % 2,
              i % 16, (i + 3) % 16, i * 61 % 4096, i * 4099));
    idle(2);
    chk("fill_last_addr", {26'b0, last_addr}, 63);
    chk("fill_full", {31'b0, full}, 1);
    chk("fill_ready", {31'b0, in_ready}, 0);
    chk("fill_count", {25'b0, count}, 64);
    saved = wr_cnt;
    in_valid = 1'b1;
    idle(10);
    in_valid = 1'b0;
    chk("full_no_write", 32'(wr_cnt), 32'(saved));
    chk("full_count_hold", {25'b0, count}, 64);
    pulse_flush();
    chk("flush_full", {31'b0, full}, 0);
    chk("flush_count", {25'b0, count}, 0);
    send(mk(2, 0, 14, 0, 0, 0, 0, 0, 0, 24'hFFFFFE));
    idle(2);
    chk("after_flush_addr", {26'b0, last_addr}, 0);
    chk("after_flush_word", last_wdata, 32'hEAFFFFFE);

    send(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(2);
    saved = wr_cnt;
    send(mk(0, 3, 14, 0, 0, 0, 1, 2, 3, 0));
    reset = 1'b1;
    #1;
    chk("async_rst_we", {31'b0, imem_we}, 0);
    idle(2);
    reset = 1'b0;
    idle(4);
    chk("rst_abort_nowrite", 32'(wr_cnt), 32'(saved));
    chk("rst_release_ready", {31'b0, in_ready}, 1);
    chk("rst_release_count", {25'b0, count}, 0);
    chk("rst_release_err", {31'b0, err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  instruction fields valid; in_ready  out  1  block can accept.
REQ-004 SHALL have ports: op_class  in  2  00 data, 01 memory, 10 branch, 11 illegal.
REQ-005 SHALL have ports: alu_op  in  3  000 add, 001 sub, 010 and, 011 orr, 101 eor, 110 mvn; 100/111 illegal.
REQ-006 SHALL have ports: cond  in  4  condition field; imm  in  1  data immediate form; s_bit  in  1  set-flags; ld  in  1  memory 1=LDR 0=STR.
REQ-007 SHALL have ports: rn  in  4; rd  in  4; src2  in  12  imm/rot or Rm field or memory offset; br_off  in  24  branch word offset.
REQ-008 SHALL have ports: flush  in  1  rewind write pointer to 0 and clear status.
REQ-009 SHALL have ports: imem_we  out  1; imem_addr  out  6  word address; imem_wdata  out  32  encoded word.
REQ-010 SHALL have ports: count  out  7  words written since reset/flush; err  out  1  sticky illegal-request flag; full  out  1  memory full.

Function
REQ-011 SHALL implement FSM states IDLE, ENC, WRITE, FULL.
REQ-012 in_ready SHALL equal (state==IDLE) & ~flush; a transfer occurs when in_valid & in_ready at a rising edge.
REQ-013 On transfer, all input fields SHALL be registered and state SHALL go IDLE->ENC.
REQ-014 In ENC the 32-bit word SHALL be built into a register; legal -> WRITE, illegal (op_class 11 or alu_op 100/111 with op_class 00) -> set err, return to IDLE, no write.
REQ-015 Data encoding: {cond, 00, imm, cmd[3:0], s_bit, rn, rd, src2}; cmd add 0100, sub 0010, and 0000, orr 1100, eor 0001, mvn 1111; for mvn the rn field SHALL be forced to 0000.
REQ-016 Memory encoding: {cond, 01, 01100, ld, rn, rd, src2} (immediate offset, pre-index, add, word, no writeback).
REQ-017 Branch encoding: {cond, 10, 10, br_off}.
REQ-018 In WRITE, imem_we SHALL be 1 for exactly one cycle with imem_addr = write pointer and imem_wdata = encoded word; pointer and count SHALL increment at that edge.
REQ-019 Latency: imem_we asserted in the second cycle after the accepting edge; throughput one word per 3 cycles.
REQ-020 If the write was to address 63, next state SHALL be FULL and full=1; otherwise IDLE; the pointer SHALL NOT wrap and no write SHALL occur while full.
REQ-021 count SHALL saturate at 64; imem_addr SHALL hold the pointer value whenever imem_we=0.
REQ-022 flush in IDLE or FULL SHALL, at the edge, zero pointer, count, err, full and enter IDLE; flush in ENC/WRITE SHALL be ignored until IDLE/FULL is reached.
REQ-023 flush and in_valid in the same IDLE cycle: flush wins, no transfer (in_ready=0).
REQ-024 err SHALL remain 1 across subsequent legal writes until flush or reset.

Reset
REQ-025 reset SHALL asynchronously force state IDLE, pointer 0, count 0, err 0, full 0, imem_we 0, imem_wdata 0, encoded-word register 0.
REQ-026 reset during ENC or WRITE SHALL abort the request; imem_we SHALL drop immediately and the word SHALL NOT be written.

Verification
REQ-027 Data imm: cond E, add, imm=1, s=0, rn 2, rd 1, src2 005 -> imem_we at addr 0, wdata 0xE2821005, count 1.
REQ-028 Data reg: cond E, sub, imm=0, rn 4, rd 3, src2 005 then LDR cond E, rn 1, rd 0, src2 008 -> 0xE0443005 at addr 0, 0xE5910008 at addr 1.
REQ-029 Branch: cond 0, br_off 0x000003 -> 0x0A000003; illegal op_class 11 -> err=1, no imem_we, count unchanged, next legal request still written.
REQ-030 Fill: 64 back-to-back legal requests -> last write addr 63, full=1, in_ready=0, count 64; 65th request never accepted; flush -> full=0, count 0, next write at addr 0.
REQ-031 Assert reset one cycle after acceptance -> no imem_we pulse, all outputs 0, in_ready=1 after release.
